stream_upsizer: RTL and testbench
=================================

# stream_upsizer

Valid/ready stream width converter: packs RATIO consecutive IN_WIDTH-bit input beats into one IN_WIDTH*RATIO-bit output word, first beat in the least-significant lane. It sits directly downstream of a skid buffer, consuming its out_data/out_valid/out_ready channel and feeding a wide AXI-Stream-style consumer. It holds a full-throughput registered output, accepting one narrow beat per cycle while the previous wide word drains.

## Interface
- IN_WIDTH, 8: input beat width in bits.
- RATIO, 4: input beats per output word; ≥2.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  IN_WIDTH  input beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_last  in  1  final beat of a packet; present only with STREAM_UPSIZER_LAST_EN.
- out_data  out  IN_WIDTH*RATIO  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- out_valid  out  1  out_data valid.
- out_ready  in  1  output word consumed when out_valid && out_ready.
- out_keep  out  RATIO  per-lane valid mask; present only with STREAM_UPSIZER_LAST_EN.
- out_last  out  1  word ends a packet; present only with STREAM_UPSIZER_LAST_EN.

## Operation
- State: lane counter `lane` (0..RATIO-1, width clog2(RATIO)), accumulator acc (lanes 0..RATIO-2), output register out_data/out_valid, registered reset flag reset_q.
- rx = in_valid && in_ready; tx = out_valid && out_ready.
- Beat is *closing* when lane == RATIO-1, or (macro on) in_last.
- rx, not closing: acc lane[`lane`] <= in_data; `lane` <= `lane`+1.
- rx, closing: out_data <= {in_data at lane `lane`, acc lanes below `lane`, zeros above}; out_valid <= 1; `lane` <= 0; acc cleared.
- tx without closing rx: out_valid <= 0; out_data holds last value.
- tx and closing rx same cycle: out_valid stays 1 with new word (flow).
- in_ready = !reset_q && (!out_valid || out_ready || (lane != RATIO-1)) without macro; with macro in_ready = !reset_q && (!out_valid || out_ready) (in_last may close any lane, so no lane-based lookahead).
- Stalled output never blocks accumulation of lanes 0..RATIO-2 (macro off).
- out_data must not change while out_valid && !out_ready.
- Counter wrap: `lane` returns to 0 only on closing rx; never increments past RATIO-1.
- Reset: `lane`=0, acc=0, out_data=0, out_valid=0, out_keep=0, out_last=0; reset_q=1 for the cycle after reset deasserts, holding in_ready low; partial accumulation mid-packet is discarded.

## Timing
- in_ready and out_valid low during reset and one cycle after; no rx possible in either.
- Latency: closing beat accepted at edge N -> out_valid high from edge N, i.e. visible cycle after acceptance.
- Throughput: one input beat per cycle sustained with out_ready high; one output word per RATIO cycles (macro off).
- in_ready depends combinationally on out_ready only; no path from in_valid/in_data/in_last to in_ready.
- out_valid, out_data, out_keep, out_last are registered outputs.

## Configuration
- STREAM_UPSIZER_LAST_EN defined: in_last, out_keep, out_last ports exist; in_last closes a word early; out_keep = bits 0..`lane` set (full word: all ones); out_last = in_last of closing beat; unused lanes zero.
- Undefined: ports absent; every word holds exactly RATIO beats; in_ready uses the lane-aware rule.

## Test plan
- Reset then stream 0x11,0x22,0x33,0x44 with out_ready=1 -> in_ready low first post-reset cycle; single word 0x44332211, out_valid one cycle after 0x44 accepted.
- Continuous 8 beats 0x01..0x08, out_ready=1 -> in_ready never drops; words 0x04030201 then 0x08070605, no gaps in input acceptance.
- Word 0x44332211 held with out_ready=0 while 0x55,0x66,0x77 sent -> all three accepted, 0x88 stalled (in_ready=0) until out_ready=1; then 0x88776655 follows; out_data stable during stall.
- Macro on: 0xAA,0xBB with in_last on 0xBB -> out_data 0x0000BBAA, out_keep 4'b0011, out_last 1; next packet restarts at lane 0.
- Reset asserted after 2 of 4 beats (0x11,0x22) then 0x33..0x36 -> output 0x36353433; partial data never appears.
- Random in_valid/out_ready over 1000 beats -> output word sequence equals reference packing of accepted beats, no loss or duplication.

Source files
------------

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow valid/ready beats into one wide registered word, first beat in lane 0.
// Optional STREAM_UPSIZER_LAST_EN adds in_last (early close), out_keep and out_last.
module stream_upsizer #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [IN_WIDTH-1:0]          in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
`ifdef STREAM_UPSIZER_LAST_EN
   input  logic                         in_last,
   output logic [RATIO-1:0]             out_keep,
   output logic                         out_last,
`endif
   output logic [IN_WIDTH*RATIO-1:0]    out_data,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int OW = IN_WIDTH * RATIO;
   localparam int AW = IN_WIDTH * (RATIO - 1);
   localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

   logic [LW-1:0] lane_r;
   logic [AW-1:0] acc_r;
   logic          reset_q_r;

   logic          rx_s;
   logic          tx_s;
   logic          closing_s;
   logic [OW-1:0] acc_ext_s;
   logic [OW-1:0] word_s;
`ifdef STREAM_UPSIZER_LAST_EN
   logic [RATIO-1:0] keep_s;
`endif

   // Handshakes, closing detection and the word a closing beat would produce
   always_comb begin
      acc_ext_s = {{IN_WIDTH{1'b0}}, acc_r};
      word_s    = {OW{1'b0}};
`ifdef STREAM_UPSIZER_LAST_EN
      keep_s    = {RATIO{1'b0}};
      // in_last may close any lane, so no lookahead on the lane count here
      in_ready  = !reset_q_r && (!out_valid || out_ready);
      closing_s = (lane_r == LAST_LANE) || in_last;
`else
      in_ready  = !reset_q_r && (!out_valid || out_ready || (lane_r != LAST_LANE));
      closing_s = (lane_r == LAST_LANE);
`endif
      rx_s = in_valid && in_ready;
      tx_s = out_valid && out_ready;
      for (int k = 0; k < RATIO; k++) begin
         if (LW'(k) < lane_r) begin
            word_s[k*IN_WIDTH +: IN_WIDTH] = acc_ext_s[k*IN_WIDTH +: IN_WIDTH];
`ifdef STREAM_UPSIZER_LAST_EN
            keep_s[k] = 1'b1;
`endif
         end else if (LW'(k) == lane_r) begin
            word_s[k*IN_WIDTH +: IN_WIDTH] = in_data;
`ifdef STREAM_UPSIZER_LAST_EN
            keep_s[k] = 1'b1;
`endif
         end else begin
            word_s[k*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{1'b0}};
         end
      end
   end

   // Lane counter, accumulator and registered output word
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_r    <= {LW{1'b0}};
         acc_r     <= {AW{1'b0}};
         out_data  <= {OW{1'b0}};
         out_valid <= 1'b0;
         reset_q_r <= 1'b1;
`ifdef STREAM_UPSIZER_LAST_EN
         out_keep  <= {RATIO{1'b0}};
         out_last  <= 1'b0;
`endif
      end else begin
         reset_q_r <= 1'b0;
         if (rx_s && closing_s) begin
            out_data  <= word_s;
            out_valid <= 1'b1;
            lane_r    <= {LW{1'b0}};
            acc_r     <= {AW{1'b0}};
`ifdef STREAM_UPSIZER_LAST_EN
            out_keep  <= keep_s;
            out_last  <= in_last;
`endif
         end else begin
            if (rx_s) begin
               for (int k = 0; k < RATIO - 1; k++) begin
                  if (LW'(k) == lane_r) begin
                     acc_r[k*IN_WIDTH +: IN_WIDTH] <= in_data;
                  end
               end
               lane_r <= lane_r + LW'(1);
            end
            if (tx_s) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer: directed scenarios plus randomized traffic against a queue-based packing model.
module tb_stream_upsizer;
   localparam int W = 8;
   localparam int R = 4;

   logic           clk;
   logic           reset;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic [W*R-1:0] out_data;
   logic           out_valid;
   logic           out_ready;
`ifdef STREAM_UPSIZER_LAST_EN
   logic           in_last;
   logic [R-1:0]   out_keep;
   logic           out_last;
`endif

   stream_upsizer #(.IN_WIDTH(W), .RATIO(R)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_UPSIZER_LAST_EN
      .in_last(in_last), .out_keep(out_keep), .out_last(out_last),
`endif
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: pending beats, completed words, handshake log
   logic [W-1:0]   part_q[$];
   logic [W*R-1:0] word_q[$];
   logic [R-1:0]   keep_q[$];
   logic           last_q[$];
   logic [W*R-1:0] dut_log[$];
   bit             post_reset = 1'b0;
   bit             exp_ov, exp_rdy, last_acc;
   logic [W*R-1:0] exp_word;
   logic [R-1:0]   exp_keep;
   logic           exp_last;
   int             tx_cnt = 0;

   task automatic model_clear();
      part_q.delete(); word_q.delete(); keep_q.delete(); last_q.delete();
      post_reset = 1'b1;
   endtask

   task automatic sample_cycle();
      @(negedge clk);
      exp_ov = (word_q.size() != 0);
`ifdef STREAM_UPSIZER_LAST_EN
      exp_rdy = !post_reset && (!exp_ov || out_ready);
`else
      exp_rdy = !post_reset && (!exp_ov || out_ready || (part_q.size() != R - 1));
`endif
      exp_word = '0; exp_keep = '0; exp_last = 1'b0;
      if (exp_ov) begin
         exp_word = word_q[0]; exp_keep = keep_q[0]; exp_last = last_q[0];
      end
   endtask

   task automatic finish_cycle();
      bit closing;
      logic [W*R-1:0] w;
      logic [R-1:0] k;
      if (out_valid === 1'b1 && out_ready === 1'b1) dut_log.push_back(out_data);
      last_acc = in_valid && exp_rdy;
      if (exp_ov && out_ready) begin
         void'(word_q.pop_front()); void'(keep_q.pop_front()); void'(last_q.pop_front());
         tx_cnt++;
      end
      if (last_acc) begin
         part_q.push_back(in_data);
         closing = (part_q.size() == R);
`ifdef STREAM_UPSIZER_LAST_EN
         closing = closing || in_last;
`endif
         if (closing) begin
            w = '0; k = '0;
            for (int i = 0; i < part_q.size(); i++) begin
               w[i*W +: W] = part_q[i];
               k[i] = 1'b1;
            end
            word_q.push_back(w);
            keep_q.push_back(k);
`ifdef STREAM_UPSIZER_LAST_EN
            last_q.push_back(in_last);
`else
            last_q.push_back(1'b0);
`endif
            part_q.delete();
         end
      end
      post_reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d);
      bit done = 1'b0;
      in_valid = 1'b1; in_data = d;
      for (int c = 0; c < 50 && !done; c++) begin
         sample_cycle();
         finish_cycle();
         done = last_acc;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_timeout beat %h not accepted within 50 cycles", d);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int c = 0; c < n; c++) begin
         sample_cycle();
         finish_cycle();
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0; reset = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      in_valid = 1'b0; out_ready = 1'b1; reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state in_ready %b out_valid %b out_data %h, want 0 0 0", in_ready, out_valid, out_data);
         end
         @(posedge clk); #1;
      end
      reset = 1'b0;
      model_clear();
      in_valid = 1'b1; in_data = 8'hEE;
      sample_cycle();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_cycle in_ready %b out_valid %b, want 0 0", in_ready, out_valid);
      end
      finish_cycle();
      in_valid = 1'b0;
   endtask

   task automatic test_basic();
      dut_log.delete();
      out_ready = 1'b1;
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      sample_cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h44332211) begin
         errors++;
         $display("FAIL basic_latency out_valid %b out_data %h, want 1 44332211", out_valid, out_data);
      end
      finish_cycle();
      idle(3);
      checks++;
      if (dut_log.size() != 1 || dut_log[0] !== 32'h44332211) begin
         errors++;
         $display("FAIL basic_word count %0d first %h, want 1 44332211", dut_log.size(), (dut_log.size() != 0) ? dut_log[0] : 32'h0);
      end
   endtask

   task automatic test_back_to_back();
      int drops = 0;
      dut_log.delete();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = W'(i);
         sample_cycle();
         if (in_ready !== 1'b1) drops++;
         finish_cycle();
      end
      idle(3);
      checks++;
      if (drops != 0) begin
         errors++;
         $display("FAIL b2b_in_ready dropped %0d cycles, want 0", drops);
      end
      checks++;
      if (dut_log.size() != 2 || dut_log[0] !== 32'h04030201 || dut_log[1] !== 32'h08070605) begin
         errors++;
         $display("FAIL b2b_words count %0d, want 2 words 04030201 08070605", dut_log.size());
      end
   endtask

   task automatic test_stall();
      logic [W-1:0] mid [3];
      mid[0] = 8'h55; mid[1] = 8'h66; mid[2] = 8'h77;
      dut_log.delete();
      out_ready = 1'b1;
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = mid[i];
         sample_cycle();
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_accum beat %h in_ready %b, want 1", mid[i], in_ready);
         end
         finish_cycle();
      end
      in_data = 8'h88;
      for (int i = 0; i < 4; i++) begin
         sample_cycle();
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h44332211) begin
            errors++;
            $display("FAIL stall_hold in_ready %b out_valid %b out_data %h, want 0 1 44332211", in_ready, out_valid, out_data);
         end
         finish_cycle();
      end
      out_ready = 1'b1;
      sample_cycle();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release in_ready %b, want 1", in_ready);
      end
      finish_cycle();
      in_valid = 1'b0;
      sample_cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h88776655) begin
         errors++;
         $display("FAIL stall_flow out_valid %b out_data %h, want 1 88776655", out_valid, out_data);
      end
      finish_cycle();
      idle(2);
      checks++;
      if (dut_log.size() != 2 || dut_log[0] !== 32'h44332211 || dut_log[1] !== 32'h88776655) begin
         errors++;
         $display("FAIL stall_words count %0d, want 2 words 44332211 88776655", dut_log.size());
      end
   endtask

   task automatic test_reset_mid();
      dut_log.delete();
      out_ready = 1'b1;
      send(8'h11); send(8'h22);
      do_reset();
      send(8'h33); send(8'h34); send(8'h35); send(8'h36);
      idle(3);
      checks++;
      if (dut_log.size() != 1 || dut_log[0] !== 32'h36353433) begin
         errors++;
         $display("FAIL reset_mid count %0d first %h, want 1 36353433", dut_log.size(), (dut_log.size() != 0) ? dut_log[0] : 32'h0);
      end
   endtask

`ifdef STREAM_UPSIZER_LAST_EN
   task automatic test_last();
      out_ready = 1'b1;
      in_last = 1'b0; send(8'hAA);
      in_last = 1'b1; send(8'hBB);
      in_last = 1'b0;
      sample_cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000BBAA || out_keep !== 4'b0011 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL last_early data %h keep %b last %b, want 0000BBAA 0011 1", out_data, out_keep, out_last);
      end
      finish_cycle();
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      sample_cycle();
      checks++;
      if (out_data !== 32'h04030201 || out_keep !== 4'b1111 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL last_restart data %h keep %b last %b, want 04030201 1111 0", out_data, out_keep, out_last);
      end
      finish_cycle();
      idle(2);
   endtask
`endif

   task automatic test_random();
      int accepted = 0;
      int bad = 0;
      int tx_start;
      dut_log.delete();
      tx_start = tx_cnt;
      for (int c = 0; c < 20000 && accepted < 1000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = W'($urandom);
`ifdef STREAM_UPSIZER_LAST_EN
         in_last   = ($urandom_range(0, 4) == 0);
`endif
         sample_cycle();
         checks++;
         if (in_ready !== exp_rdy || out_valid !== exp_ov || (exp_ov && out_data !== exp_word)) begin
            errors++;
            if (bad < 10)
               $display("FAIL rnd_cycle %0d in_ready %b/%b out_valid %b/%b out_data %h/%h (got/want)",
                        c, in_ready, exp_rdy, out_valid, exp_ov, out_data, exp_word);
            bad++;
         end
`ifdef STREAM_UPSIZER_LAST_EN
         if (exp_ov) begin
            checks++;
            if (out_keep !== exp_keep || out_last !== exp_last) begin
               errors++;
               $display("FAIL rnd_keep_last keep %b/%b last %b/%b (got/want)", out_keep, exp_keep, out_last, exp_last);
            end
         end
`endif
         finish_cycle();
         if (last_acc) accepted++;
      end
`ifdef STREAM_UPSIZER_LAST_EN
      in_last = 1'b0;
`endif
      out_ready = 1'b1;
      idle(4);
      checks++;
      if (accepted != 1000) begin
         errors++;
         $display("FAIL rnd_progress accepted %0d beats, want 1000", accepted);
      end
      checks++;
      if (dut_log.size() != tx_cnt - tx_start) begin
         errors++;
         $display("FAIL rnd_word_count dut %0d model %0d", dut_log.size(), tx_cnt - tx_start);
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
      in_last = 1'b0;
`endif
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_reset_mid();
`ifdef STREAM_UPSIZER_LAST_EN
      test_last();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
